// File: rtl/cp0_unit_pkg.sv
// Shared definitions for the MIPS coprocessor 0: register numbers, exception codes,
// SR/Cause field positions and the exception-tag layout.
package cp0_unit_pkg;

  localparam logic [4:0] CP0_REG_SR    = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE = 5'd13;
  localparam logic [4:0] CP0_REG_EPC   = 5'd14;
  localparam logic [4:0] CP0_REG_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int SR_IM_LSB     = 10;
  localparam int SR_EXL_BIT    = 1;
  localparam int SR_IE_BIT     = 0;
  localparam int CAUSE_BD_BIT  = 31;
  localparam int CAUSE_IP_LSB  = 10;
  localparam int CAUSE_EXC_LSB = 2;

  localparam int EXC_TAG_W     = 6;
  localparam int EXC_VLD_BIT   = 5;

endpackage

// File: rtl/cp0_unit.sv
// Coprocessor 0 at the M stage: SR/Cause/EPC/PRId, interrupt/exception arbitration
// and the flush/redirect request toward the NPC unit.
module cp0_unit
  import cp0_unit_pkg::*;
#(
  parameter logic [31:0] PRID     = 32'h4255_4143,
  parameter logic [31:0] SR_RESET = 32'h0000_FC01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] PC_M,
  input  logic        BD_M,
  input  logic [5:0]  EXC_M,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        IntReq,
  output logic [31:0] EPC_out,
  output logic [31:0] DOut
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] epc_q, epc_d;

  logic        int_hit;
  logic        exc_hit;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  assign int_hit = (|(HWInt & im_q)) & ie_q & ~exl_q;
  assign exc_hit = EXC_M[EXC_VLD_BIT] & ~exl_q;
  assign IntReq  = int_hit | exc_hit;

  assign sr_word    = {16'b0, im_q, 8'b0, exl_q, ie_q};
  assign cause_word = {bd_q, 15'b0, ip_q, 3'b0, code_q, 2'b0};
  assign EPC_out    = epc_q;

  always_comb begin
    DOut = 32'b0;
    case (A1)
      CP0_REG_SR:    DOut = sr_word;
      CP0_REG_CAUSE: DOut = cause_word;
      CP0_REG_EPC:   DOut = epc_q;
      CP0_REG_PRID:  DOut = PRID;
      default:       DOut = 32'b0;
    endcase
  end

  always_comb begin
    im_d   = im_q;
    exl_d  = exl_q;
    ie_d   = ie_q;
    bd_d   = bd_q;
    code_d = code_q;
    epc_d  = epc_q;
    ip_d   = HWInt;
    if (IntReq) begin
      // Entry swallows any mtc0/eret issued in the same cycle.
      exl_d  = 1'b1;
      code_d = int_hit ? EXC_INT : EXC_M[4:0];
      bd_d   = BD_M;
      epc_d  = (BD_M ? (PC_M - 32'd4) : PC_M) & 32'hFFFF_FFFC;
    end else begin
      if (WE && (A2 == CP0_REG_SR)) begin
        im_d  = DIn[SR_IM_LSB +: 6];
        exl_d = DIn[SR_EXL_BIT];
        ie_d  = DIn[SR_IE_BIT];
      end
      if (WE && (A2 == CP0_REG_EPC)) begin
        epc_d = DIn;
      end
      if (EXLClr) begin
        exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      im_q   <= SR_RESET[SR_IM_LSB +: 6];
      exl_q  <= SR_RESET[SR_EXL_BIT];
      ie_q   <= SR_RESET[SR_IE_BIT];
      bd_q   <= 1'b0;
      ip_q   <= 6'b0;
      code_q <= 5'b0;
      epc_q  <= 32'b0;
    end else begin
      im_q   <= im_d;
      exl_q  <= exl_d;
      ie_q   <= ie_d;
      bd_q   <= bd_d;
      ip_q   <= ip_d;
      code_q <= code_d;
      epc_q  <= epc_d;
    end
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Bench for cp0_unit: directed vector table with constant expectations, then random
// traffic compared against a register-word reference model.
module tb_cp0_unit;

  localparam logic [31:0] PRID_V = 32'h4255_4143;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  a1, a2;
  logic [31:0] din;
  logic        we;
  logic [31:0] pc;
  logic        bd;
  logic [5:0]  exc;
  logic [5:0]  hw;
  logic        exlclr;
  logic        intreq;
  logic [31:0] epc_out;
  logic [31:0] dout;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cp0_unit dut (
    .clk(clk), .reset(rst_n), .A1(a1), .A2(a2), .DIn(din), .WE(we),
    .PC_M(pc), .BD_M(bd), .EXC_M(exc), .HWInt(hw), .EXLClr(exlclr),
    .IntReq(intreq), .EPC_out(epc_out), .DOut(dout)
  );

  typedef struct {
    logic        rst_n;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] din;
    logic        we;
    logic [31:0] pc;
    logic        bd;
    logic [5:0]  exc;
    logic [5:0]  hw;
    logic        clr;
    logic        chk;
    logic        ir;
    logic [31:0] dout;
    logic [31:0] epc;
  } vec_t;

  vec_t tbl[24];

  // reference model state, kept as architectural 32-bit words
  logic [31:0] m_sr, m_cause, m_epc;
  bit          m_valid = 0;

  function automatic vec_t v(logic r, logic [4:0] ra1, logic [4:0] ra2, logic [31:0] rdin,
                             logic rwe, logic [31:0] rpc, logic rbd, logic [5:0] rexc,
                             logic [5:0] rhw, logic rclr, logic rchk, logic rir,
                             logic [31:0] rdout, logic [31:0] repc);
    vec_t t;
    t.rst_n = r; t.a1 = ra1; t.a2 = ra2; t.din = rdin; t.we = rwe; t.pc = rpc;
    t.bd = rbd; t.exc = rexc; t.hw = rhw; t.clr = rclr; t.chk = rchk; t.ir = rir;
    t.dout = rdout; t.epc = repc;
    return t;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic model_intreq();
    logic ih, eh;
    ih = ((hw & m_sr[15:10]) != 6'b0) && m_sr[0] && !m_sr[1];
    eh = exc[5] && !m_sr[1];
    return ih || eh;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] r);
    case (r)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID_V;
      default: return 32'b0;
    endcase
  endfunction

  // compare outputs against model, then clock once and advance the model
  task automatic cycle();
    logic [31:0] n_sr, n_cause, n_epc;
    logic        ir, ih;
    if (m_valid) begin
      chk32("model_intreq", {31'b0, intreq}, {31'b0, model_intreq()});
      chk32("model_dout", dout, model_read(a1));
      chk32("model_epc", epc_out, m_epc);
    end
    ir = model_intreq();
    ih = ((hw & m_sr[15:10]) != 6'b0) && m_sr[0] && !m_sr[1];
    n_sr = m_sr; n_epc = m_epc;
    n_cause = (m_cause & ~32'h0000_FC00) | ({26'b0, hw} << 10);
    if (!rst_n) begin
      n_sr = 32'h0000_FC01; n_cause = 32'b0; n_epc = 32'b0;
    end else if (ir) begin
      n_sr = n_sr | 32'h2;
      n_cause[6:2] = ih ? 5'd0 : exc[4:0];
      n_cause[31]  = bd;
      n_epc = (bd ? pc - 32'd4 : pc) & ~32'd3;
    end else begin
      if (we && a2 == 5'd12) n_sr = din & 32'h0000_FC03;
      if (we && a2 == 5'd14) n_epc = din;
      if (exlclr) n_sr = n_sr & ~32'h2;
    end
    @(posedge clk);
    #1;
    m_sr = n_sr; m_cause = n_cause; m_epc = n_epc;
    if (!rst_n) m_valid = 1;
  endtask

  initial begin
    rst_n = 0; a1 = 0; a2 = 0; din = 0; we = 0; pc = 0; bd = 0; exc = 0; hw = 0; exlclr = 0;
    m_sr = 0; m_cause = 0; m_epc = 0;

    tbl[0]  = v(0, 12, 0,  0,            0, 0,        0, 6'h00, 6'h00, 0, 0, 0, 0,            0);
    tbl[1]  = v(0, 12, 0,  0,            0, 0,        0, 6'h00, 6'h00, 0, 1, 0, 32'h0000FC01, 0);
    tbl[2]  = v(1, 15, 0,  0,            0, 0,        0, 6'h00, 6'h00, 0, 1, 0, PRID_V,       0);
    tbl[3]  = v(1, 14, 0,  0,            0, 0,        0, 6'h00, 6'h00, 0, 1, 0, 0,            0);
    tbl[4]  = v(1, 13, 0,  0,            0, 32'h3008, 0, 6'h2A, 6'h00, 0, 1, 1, 0,            0);
    tbl[5]  = v(1, 13, 0,  0,            0, 32'h3008, 0, 6'h2A, 6'h00, 0, 1, 0, 32'h28,       32'h3008);
    tbl[6]  = v(1, 12, 0,  0,            0, 0,        0, 6'h00, 6'h00, 1, 1, 0, 32'h0000FC03, 32'h3008);
    tbl[7]  = v(1, 12, 0,  0,            0, 32'h3010, 1, 6'h2C, 6'h04, 0, 1, 1, 32'h0000FC01, 32'h3008);
    tbl[8]  = v(1, 13, 0,  0,            0, 0,        0, 6'h00, 6'h00, 0, 1, 0, 32'h80001000, 32'h300C);
    tbl[9]  = v(1, 12, 12, 32'hFFFFFFFF, 1, 0,        0, 6'h00, 6'h00, 0, 1, 0, 32'h0000FC03, 32'h300C);
    tbl[10] = v(1, 12, 0,  0,            0, 0,        0, 6'h00, 6'h01, 0, 1, 0, 32'h0000FC03, 32'h300C);
    tbl[11] = v(1, 12, 0,  0,            0, 0,        0, 6'h00, 6'h01, 1, 1, 0, 32'h0000FC03, 32'h300C);
    tbl[12] = v(1, 12, 0,  0,            0, 32'h3020, 0, 6'h00, 6'h01, 0, 1, 1, 32'h0000FC01, 32'h300C);
    tbl[13] = v(1, 14, 0,  0,            0, 0,        0, 6'h00, 6'h00, 1, 1, 0, 32'h3020,     32'h3020);
    tbl[14] = v(1, 12, 12, 0,            1, 32'h3030, 0, 6'h24, 6'h00, 0, 1, 1, 32'h0000FC01, 32'h3020);
    tbl[15] = v(1, 12, 0,  0,            0, 0,        0, 6'h00, 6'h00, 0, 1, 0, 32'h0000FC03, 32'h3030);
    tbl[16] = v(1, 13, 14, 32'h12345678, 1, 0,        0, 6'h00, 6'h00, 0, 1, 0, 32'h10,       32'h3030);
    tbl[17] = v(1, 14, 13, 32'hFFFFFFFF, 1, 0,        0, 6'h00, 6'h00, 0, 1, 0, 32'h12345678, 32'h12345678);
    tbl[18] = v(1, 13, 12, 32'h403,      1, 0,        0, 6'h00, 6'h00, 1, 1, 0, 32'h10,       32'h12345678);
    tbl[19] = v(1, 12, 0,  0,            0, 32'h3008, 0, 6'h2A, 6'h00, 0, 1, 1, 32'h401,      32'h12345678);
    tbl[20] = v(0, 12, 0,  0,            0, 0,        0, 6'h00, 6'h00, 0, 1, 0, 32'h403,      32'h3008);
    tbl[21] = v(1, 12, 0,  0,            0, 0,        0, 6'h00, 6'h00, 0, 1, 0, 32'h0000FC01, 0);
    tbl[22] = v(1, 13, 0,  0,            0, 0,        0, 6'h00, 6'h00, 0, 1, 0, 0,            0);
    tbl[23] = v(1, 7,  0,  0,            0, 0,        0, 6'h00, 6'h00, 0, 1, 0, 0,            0);

    @(posedge clk);
    #1;
    for (int i = 0; i < 24; i++) begin
      rst_n = tbl[i].rst_n; a1 = tbl[i].a1; a2 = tbl[i].a2; din = tbl[i].din;
      we = tbl[i].we; pc = tbl[i].pc; bd = tbl[i].bd; exc = tbl[i].exc;
      hw = tbl[i].hw; exlclr = tbl[i].clr;
      #4;
      if (tbl[i].chk) begin
        chk32($sformatf("vec%0d_intreq", i), {31'b0, intreq}, {31'b0, tbl[i].ir});
        chk32($sformatf("vec%0d_dout", i), dout, tbl[i].dout);
        chk32($sformatf("vec%0d_epc", i), epc_out, tbl[i].epc);
      end
      cycle();
    end

    for (int i = 0; i < 400; i++) begin
      rst_n  = ($urandom_range(63) != 0);
      a1     = 5'($urandom_range(16, 10));
      a2     = 5'($urandom_range(15, 11));
      din    = $urandom;
      we     = ($urandom_range(2) == 0);
      pc     = $urandom;
      bd     = $urandom_range(1);
      exc    = {($urandom_range(3) == 0), 5'($urandom)};
      hw     = ($urandom_range(7) == 0) ? 6'($urandom) : 6'b0;
      exlclr = ($urandom_range(3) == 0);
      #4;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
